// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with a memory-wait timeout and an absorbing fault state.
// Optional performance counters are built only when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic        fault,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
);

  localparam int unsigned WaitW = (WAIT_MAX > 15) ? $clog2(WAIT_MAX + 1) : 4;
  localparam logic [WaitW-1:0] WaitMaxC = WaitW'(WAIT_MAX);

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpBne   = 6'd5;
  localparam logic [5:0] OpAddi  = 6'd8;
  localparam logic [5:0] OpJ     = 6'd2;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StFault  = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Only meaningful in the memory-wait states; completion (mem_ready) always wins.
  assign timeout = (WAIT_MAX != 0) && (wait_q == WaitMaxC) && !mem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StFault;
      end
      StDecode: begin
        case (opcode)
          OpRtype:      state_d = StExec;
          OpLw, OpSw:   state_d = StMemAdr;
          OpBeq, OpBne: state_d = StBranch;
          OpAddi:       state_d = StAddiEx;
          OpJ:          state_d = StJump;
          default:      state_d = StFault;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready)    state_d = StMemWb;
        else if (timeout) state_d = StFault;
      end
      StMemWb: state_d = StFetch;
      StMemWr: begin
        if (mem_ready)    state_d = StFetch;
        else if (timeout) state_d = StFault;
      end
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
      StFault:  state_d = StFault;
      default:  state_d = StFault;
    endcase
  end

  // Counter restarts whenever the state changes, so each wait state sees a fresh count.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (!mem_ready) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = ((opcode == OpBeq) && zero) || ((opcode == OpBne) && !zero);
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb: reg_write = 1'b1;
      StJump: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
    // The async reset already forces FETCH; the strobes must also be quiet while it is held.
    if (reset) begin
      pc_write = 1'b0;
      ir_write = 1'b0;
    end
  end

  always_comb begin
    assert (!(mem_read && mem_write));
  end

  assign state = state_q;
  assign fault = (state_q == StFault);

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_q, retire_q;
  logic        retire;

  assign retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBranch) ||
                  (state_q == StAddiWb) || (state_q == StJump) ||
                  ((state_q == StMemWr) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (state_q != StFault) cycle_q <= cycle_q + 32'd1;
      if (retire)             retire_q <= retire_q + 32'd1;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction traces built from the
// instruction-level state sequences, plus directed reset, timeout and fault scenarios.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int unsigned WaitMax = 4;
`ifdef MULTICYCLE_CTRL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic        fault;
  logic [31:0] cycle_cnt, retire_cnt;
  logic [14:0] ctrl;

  int checks = 0;
  int errors = 0;
  int cyc_m  = 0;
  int ret_m  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_MAX(WaitMax)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state      (state),
    .fault      (fault),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
  );

  assign ctrl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op, pc_src};

  // Control word per state, straight from the state table:
  // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
  //  alu_src_b, alu_op, pc_src}
  function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op,
                                           input logic z);
    logic pw;
    case (st)
      0:  return {mr, mr, 7'b0100000, 2'b01, 2'b00, 2'b00};
      1:  return {9'b000000000, 2'b11, 2'b00, 2'b00};
      2:  return {9'b000000001, 2'b10, 2'b00, 2'b00};
      3:  return {9'b001100000, 2'b00, 2'b00, 2'b00};
      4:  return {9'b000001010, 2'b00, 2'b00, 2'b00};
      5:  return {9'b001010000, 2'b00, 2'b00, 2'b00};
      6:  return {9'b000000001, 2'b00, 2'b10, 2'b00};
      7:  return {9'b000001100, 2'b00, 2'b00, 2'b00};
      8: begin
        pw = ((op == 6'd4) && z) || ((op == 6'd5) && !z);
        return {pw, 8'b00000001, 2'b00, 2'b01, 2'b01};
      end
      9:  return {9'b000000001, 2'b10, 2'b00, 2'b00};
      10: return {9'b000001000, 2'b00, 2'b00, 2'b00};
      11: return {9'b100000000, 2'b00, 2'b00, 2'b10};
      default: return 15'd0;
    endcase
  endfunction

  // Leaves the bench just after a falling edge with reset released and the model cleared.
  task automatic do_reset();
    reset = 1'b1;
    opcode = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc_m = 0;
    ret_m = 0;
  endtask

  // One instruction: fw/mw are the number of not-ready cycles in FETCH and in the memory state.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                           input string tag);
    int   sts[$];
    logic mrs[$];
    for (int i = 0; i < fw; i++) begin sts.push_back(0); mrs.push_back(1'b0); end
    sts.push_back(0); mrs.push_back(1'b1);
    sts.push_back(1); mrs.push_back(1'($urandom_range(0, 1)));
    case (op)
      6'd0: begin sts.push_back(6); sts.push_back(7); end
      6'd35: begin
        sts.push_back(2);
        mrs.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin sts.push_back(3); mrs.push_back(1'b0); end
        sts.push_back(3); mrs.push_back(1'b1);
        sts.push_back(4);
      end
      6'd43: begin
        sts.push_back(2);
        mrs.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin sts.push_back(5); mrs.push_back(1'b0); end
        sts.push_back(5); mrs.push_back(1'b1);
      end
      6'd4, 6'd5: sts.push_back(8);
      6'd8: begin sts.push_back(9); sts.push_back(10); end
      default: sts.push_back(11);
    endcase
    while (mrs.size() < sts.size()) mrs.push_back(1'($urandom_range(0, 1)));

    for (int k = 0; k < sts.size(); k++) begin
      opcode = op;
      zero = z;
      mem_ready = mrs[k];
      #1;
      checks++;
      if (state !== 4'(sts[k])) begin
        errors++;
        $display("FAIL %s state cyc %0d: got %0d want %0d", tag, k, state, sts[k]);
      end
      checks++;
      if (ctrl !== exp_ctrl(sts[k], mrs[k], op, z)) begin
        errors++;
        $display("FAIL %s ctrl cyc %0d: got %b want %b", tag, k, ctrl,
                 exp_ctrl(sts[k], mrs[k], op, z));
      end
      checks++;
      if (fault !== 1'b0) begin
        errors++;
        $display("FAIL %s fault cyc %0d: got %b want 0", tag, k, fault);
      end
      checks++;
      if (cycle_cnt !== (PerfEn ? 32'(cyc_m) : 32'd0) ||
          retire_cnt !== (PerfEn ? 32'(ret_m) : 32'd0)) begin
        errors++;
        $display("FAIL %s counters cyc %0d: got %0d/%0d want %0d/%0d", tag, k, cycle_cnt,
                 retire_cnt, PerfEn ? cyc_m : 0, PerfEn ? ret_m : 0);
      end
      cyc_m++;
      if (k == sts.size() - 1) ret_m++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    #2;
    checks++;
    if (state !== 4'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got state %0d fault %b want 0 0", state, fault);
    end
    checks++;
    if (ctrl !== exp_ctrl(0, 1'b0, 6'd0, 1'b0)) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want %b", ctrl, exp_ctrl(0, 1'b0, 6'd0, 1'b0));
    end
    checks++;
    if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, retire_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_directed();
    do_reset();
    run_instr(6'd0, 1'b0, 0, 0, "rtype");
    #1;
    checks++;
    if (retire_cnt !== (PerfEn ? 32'd1 : 32'd0) || state !== 4'd0) begin
      errors++;
      $display("FAIL rtype_retire: got %0d state %0d want %0d state 0", retire_cnt, state,
               PerfEn ? 1 : 0);
    end
    @(negedge clk);
    do_reset();
    run_instr(6'd35, 1'b0, 0, 3, "lw_slow");
    run_instr(6'd5, 1'b0, 0, 0, "bne_taken");
    run_instr(6'd4, 1'b0, 0, 0, "beq_not_taken");
    run_instr(6'd4, 1'b1, 0, 0, "beq_taken");
    run_instr(6'd43, 1'b0, 1, 2, "sw");
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd2};
    do_reset();
    for (int n = 0; n < 60; n++) begin
      run_instr(ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, WaitMax)), int'($urandom_range(0, WaitMax)), "random");
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL timeout_wait cyc %0d: got state %0d want 0", k, state);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (state !== 4'd15 || fault !== 1'b1 || ctrl !== 15'd0) begin
      errors++;
      $display("FAIL timeout_fault: got state %0d fault %b ctrl %b want 15 1 0", state, fault,
               ctrl);
    end
    checks++;
    if (cycle_cnt !== (PerfEn ? 32'd5 : 32'd0)) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d want %0d", cycle_cnt, PerfEn ? 5 : 0);
    end
    @(negedge clk);
    do_reset();
    run_instr(6'd2, 1'b0, 4, 0, "timeout_edge");

    // Memory read stuck low: five MEMRD cycles then FAULT.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      int exp_st;
      exp_st = (k < 3) ? k : ((k < 8) ? 3 : 15);
      opcode = 6'd35;
      mem_ready = (k == 0);
      #1;
      checks++;
      if (state !== 4'(exp_st)) begin
        errors++;
        $display("FAIL memrd_timeout cyc %0d: got state %0d want %0d", k, state, exp_st);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'd63;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      opcode = (k % 2 == 0) ? 6'd63 : 6'd0;
      #1;
      checks++;
      if (state !== 4'd15 || fault !== 1'b1 || ctrl !== 15'd0 ||
          cycle_cnt !== (PerfEn ? 32'd2 : 32'd0)) begin
        errors++;
        $display("FAIL illegal_hold cyc %0d: got state %0d fault %b ctrl %b cyc %0d", k, state,
                 fault, ctrl, cycle_cnt);
      end
      @(negedge clk);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || fault !== 1'b0 || cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got state %0d fault %b cyc %0d want 0 0 0", state, fault,
               cycle_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      opcode = 6'd35;
      mem_ready = (k == 0);
      @(negedge clk);
    end
    #1;
    checks++;
    if (state !== 4'd3) begin
      errors++;
      $display("FAIL mid_reset_setup: got state %0d want 3", state);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || retire_cnt !== 32'd0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got state %0d retire %0d want 0 0", state, retire_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 15: the memory-wait timeout in cycles; a value of 0 disables the timeout.
REQ-002 clk  in  1  single clock for the block; every register updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  instr[31:26] taken from the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory access-complete strobe.
REQ-007 pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath controls.
REQ-008 alu_src_b  out  2  ALU B operand select: 00 reg, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 2.
REQ-009 alu_op  out  2  ALU operation: 00 add, 01 subtract, 10 decode funct.
REQ-010 pc_src  out  2  next-PC select: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-011 state  out  4  current state encoding.
REQ-012 fault  out  1  sticky error flag.
REQ-013 cycle_cnt, retire_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-014 The state encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, FAULT=15.
REQ-015 Outputs SHALL be Moore-decoded from state; the exceptions are pc_write, ir_write and the next-state logic, which also depend on mem_ready, zero and opcode.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
 - Stay in FETCH while mem_ready=0.
 - When mem_ready=1: ir_write=1 and pc_write=1 for that cycle, then go to DECODE.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
 - 0 -> EXEC; 35 or 43 -> MEMADR; 4 or 5 -> BRANCH; 8 -> ADDIEX; 2 -> JUMP.
 - Any other opcode -> FAULT.
REQ-018 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state is MEMRD if opcode=35, otherwise MEMWR.
REQ-019 MEMRD: mem_read=1, iord=1; hold until mem_ready=1, then go to MEMWB.
 - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-020 MEMWR: mem_write=1, iord=1; hold until mem_ready=1, then go to FETCH.
REQ-021 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALUWB.
 - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; next state FETCH.
 - pc_write=(opcode==4 & zero) | (opcode==5 & ~zero).
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDIWB.
 - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-024 JUMP: pc_write=1, pc_src=10; next state FETCH.
REQ-025 Every control not listed for a state SHALL be 0.
REQ-026 Memory-wait timeout (FETCH, MEMRD, MEMWR only):
 - A 4-bit-or-wider wait counter SHALL clear on entry to each of these states and increment on each cycle in which mem_ready=0.
 - If WAIT_MAX>0 and the counter equals WAIT_MAX while mem_ready=0, the next state SHALL be FAULT.
 - If mem_ready=1 on that same cycle, completion wins and no FAULT occurs.
REQ-027 FAULT is absorbing: all controls are 0, fault=1, and the block leaves FAULT only on reset.
REQ-028 mem_read and mem_write SHALL never be asserted together.

Reset
REQ-029 Asserting reset SHALL immediately force, without waiting for clk: state=FETCH, wait counter=0, fault=0, cycle_cnt=0, retire_cnt=0.
REQ-030 During reset the combinational outputs SHALL equal the FETCH decode; pc_write and ir_write SHALL be 0 while reset=1.
REQ-031 Reset asserted in the middle of an instruction SHALL abandon that instruction without retiring it.

Configuration
REQ-032 With MULTICYCLE_CTRL_PERF_EN defined:
 - cycle_cnt SHALL increment every cycle when not in FAULT.
 - retire_cnt SHALL increment on the final cycle of each instruction: MEMWB, MEMWR with mem_ready=1, ALUWB, BRANCH, ADDIWB, JUMP.
 - Both counters wrap modulo 2^32.
REQ-033 Without MULTICYCLE_CTRL_PERF_EN: cycle_cnt and retire_cnt SHALL be constant 0 and no counter flops SHALL be present.

Verification
REQ-034 R-type: mem_ready=1, opcode=0 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; retire_cnt=1.
REQ-035 lw with slow memory: opcode=35, mem_ready low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; mem_read held high through all MEMRD cycles.
REQ-036 Branch: opcode=5, zero=0 -> pc_write=1 with pc_src=01 in BRANCH; opcode=4, zero=0 -> pc_write=0.
REQ-037 Illegal opcode=63 -> FAULT reached after DECODE, fault=1 held for 20 cycles; asserting reset mid-cycle -> state=0 and fault=0 without waiting for a clk edge.
REQ-038 Timeout with WAIT_MAX=4 and mem_ready stuck at 0 in FETCH -> FAULT entered exactly 5 cycles after reset release; a repeat run with mem_ready=1 on the fifth cycle -> DECODE, no fault.
